// File: rtl/ofifo_pkg.sv
// Shared constants and helpers for the output-side column FIFO bank.
package ofifo_pkg;

  localparam int COL         = 8;
  localparam int PSUM_BW     = 16;
  localparam int OFIFO_DEPTH = 64;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-lane circular FIFO with a wrap bit on each pointer; head is combinational.
module ofifo_lane
  import ofifo_pkg::*;
#(
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr,
  input  logic          rd,
  input  logic [bw-1:0] in,
  output logic [bw-1:0] head,
  output logic          o_empty,
  output logic          o_full
);

  localparam int AW = clog2(depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [bw-1:0] mem_q [depth];
  logic          do_wr, do_rd;

  always_comb begin
    o_empty  = (wr_ptr_q == rd_ptr_q);
    o_full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Fullness and emptiness are judged on pre-edge pointers.
    do_wr    = wr & ~o_full;
    do_rd    = rd & ~o_empty;
    wr_ptr_d = do_wr ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_rd ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    head     = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; contents are meaningless until pointers cover them.
  always_ff @(posedge clk) begin
    if (!reset && do_wr) mem_q[wr_ptr_q[AW-1:0]] <= in;
  end

endmodule

// File: rtl/ofifo.sv
// Column FIFO bank: lanes fill independently, rows pop out aligned once every lane holds data.
module ofifo
  import ofifo_pkg::*;
#(
  parameter int col   = COL,
  parameter int bw    = PSUM_BW,
  parameter int depth = OFIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid
);

  logic [col-1:0]    lane_empty;
  logic [col-1:0]    lane_full;
  logic [col*bw-1:0] head_row;
  logic [col*bw-1:0] out_q, out_d;
  logic              rd_accept;

  for (genvar i = 0; i < col; i++) begin : g_lane
    ofifo_lane #(
      .bw   (bw),
      .depth(depth)
    ) u_lane (
      .clk    (clk),
      .reset  (reset),
      .wr     (wr[i]),
      .rd     (rd_accept),
      .in     (in[i*bw +: bw]),
      .head   (head_row[i*bw +: bw]),
      .o_empty(lane_empty[i]),
      .o_full (lane_full[i])
    );
  end

  always_comb begin
    o_valid   = &(~lane_empty);
    o_full    = |lane_full;
    o_ready   = ~o_full;
    // A row pops only when every lane can supply an entry.
    rd_accept = rd & o_valid;
    out_d     = rd_accept ? head_row : out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign out = out_q;

endmodule

// File: doc/ofifo.md
# ofifo

Output-side column FIFO bank of the systolic array: one FIFO lane per PE column, written independently as each column's partial sum emerges (skewed in time), and read out as one aligned row only when every lane holds data. It is the counterpart of the row-staggered input L0 buffer: the L0 buffer de-aligns rows going into the array, and this block re-aligns columns coming out of it before write-back to psum SRAM.

## Interface
- `col`, 8, number of lanes (PE columns)
- `bw`, 16, data width per lane (psum width)
- `depth`, 64, entries per lane; power of two, ≥2
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `in`  in  col*bw  lane i data at bits [(i+1)*bw-1 : i*bw]
- `wr`  in  col  per-lane write strobe; bit i writes lane i
- `rd`  in  1  pop one aligned row from all lanes
- `out`  out  col*bw  registered row output, same lane packing as `in`
- `o_full`  out  1  any lane full
- `o_ready`  out  1  ~o_full
- `o_valid`  out  1  every lane non-empty; a full row is available

## Operation
- Each lane is a circular FIFO with wr_ptr/rd_ptr of log2(depth)+1 bits; MSB is the wrap bit.
  - Empty: pointers equal.
  - Full: MSBs differ and lower bits equal.
- Write: lane i stores in[i] at wr_ptr and increments wr_ptr when wr[i]=1 and lane i is not full (pre-edge state). A write to a full lane is dropped. Pointer, data and flags stay unchanged. It is not an error.
- Read: accepted when rd=1 and o_valid=1 (pre-edge state).
  - All lanes pop together; every rd_ptr increments.
  - out loads the head entry of every lane.
- rd with o_valid=0 is ignored. No pointer moves, and out holds its value.
- Simultaneous write and read on a lane: both take effect and occupancy is unchanged. Fullness is judged before the edge, so a write to a full lane is still dropped even if a read happens on the same edge.
- Pointers wrap modulo 2*depth. Storage index is the lower log2(depth) bits.
- Flags are combinational from pointers:
  - o_full = |full[i]
  - o_ready = ~o_full
  - o_valid = &(~empty[i])
- Reset: all pointers go to 0 and out goes to 0. After the reset edge: o_valid=0, o_full=0, o_ready=1. Storage contents are don't-care. Reset mid-operation discards all buffered data and overrides any wr/rd in the same cycle.

## Timing
- Write-to-flag: lane i written at edge N makes empty[i] fall after edge N. o_valid rises in the cycle after the edge that writes the last empty lane.
- Read latency: rd accepted at edge N puts the row on out right after edge N. out is stable until the next accepted read or reset.
- Back-to-back reads: rd held high pops one row per cycle while o_valid=1. Reads stop without underflow the cycle the first lane empties.
- o_full asserts right after the edge that fills any lane. It deasserts right after the next accepted read.
- Reset values: out=0, o_valid=0, o_full=0, o_ready=1.

## Structure
- Shared package holds:
  - default constants COL=8, PSUM_BW=16, OFIFO_DEPTH=64
  - a clog2 function for pointer width
- One sub-module, `ofifo_lane`: a single-lane FIFO.
  - Parameters: bw, depth.
  - Ports: clk, reset, wr, rd, in, head data, o_empty, o_full.
  - The lane exposes its head combinationally. The top-level `ofifo` owns the `out` register, the aligned-read qualification and flag reduction.
  - `ofifo` instantiates `col` lanes in a generate loop.

## Test plan
- Reset, then idle 3 cycles: out=0, o_valid=0, o_full=0, o_ready=1. rd=1 while empty causes no change.
- Skewed fill: col=8, write lane i with value 16'h100+i at cycle i (wr one-hot shifting) → o_valid=0 through cycle 7 and 1 from cycle 8. rd at cycle 8 → out={16'h107,…,16'h100} after that edge, and o_valid returns to 0.
- Fill lane 0 with 64 writes (16'h0000–16'h003F) while lanes 1–7 stay empty:
  - o_full=1 and o_ready=0 after the 64th write.
  - A 65th write of 16'hFFFF is dropped.
  - After filling lanes 1–7 and doing 64 reads, lane 0 yields 16'h0000…16'h003F in order.
- Wrap-around: 3 passes of 40 writes and 40 reads per lane with incrementing data → output order and values match a reference queue. Flags are correct across pointer wrap.
- Simultaneous wr and rd: all lanes hold 1 entry; then wr=8'hFF and rd=1 every cycle for 20 cycles → o_valid stays 1, occupancy stays 1, and out shows the data written one cycle earlier.
- Reset mid-stream: with 5 rows buffered, assert reset together with rd=1 and wr=8'hFF → out=0, o_valid=0 after the edge, and subsequent data starts from empty.
